// File: rtl/ram_line_fill_if.sv
// Cache <-> main-memory request/response bundle for ram_line_fill.
// Optional CRITICAL_WORD_FIRST_EN adds the early_valid/early_data pair.
interface ram_line_fill_if #(
  parameter int RAM_ADDRESS_BITS = 10,
  parameter int DATA_BITS        = 32,
  parameter int BLOCK_BITS       = 2
);
  localparam int BLOCK_SIZE = 2 ** BLOCK_BITS;

  logic [RAM_ADDRESS_BITS-1:0] req_address;
  logic                        req_read_en;
  logic [DATA_BITS-1:0]        req_write_data;
  logic                        req_write_en;
  logic                        busy;
  logic                        ram_valid;
  logic [DATA_BITS-1:0]        ram_data [BLOCK_SIZE];

`ifdef CRITICAL_WORD_FIRST_EN
  logic                        early_valid;
  logic [DATA_BITS-1:0]        early_data;

  modport master (
    output req_address,
    output req_read_en,
    output req_write_data,
    output req_write_en,
    input  busy,
    input  ram_valid,
    input  ram_data,
    input  early_valid,
    input  early_data
  );

  modport slave (
    input  req_address,
    input  req_read_en,
    input  req_write_data,
    input  req_write_en,
    output busy,
    output ram_valid,
    output ram_data,
    output early_valid,
    output early_data
  );
`else
  modport master (
    output req_address,
    output req_read_en,
    output req_write_data,
    output req_write_en,
    input  busy,
    input  ram_valid,
    input  ram_data
  );

  modport slave (
    input  req_address,
    input  req_read_en,
    input  req_write_data,
    input  req_write_en,
    output busy,
    output ram_valid,
    output ram_data
  );
`endif

endinterface

// File: rtl/ram_line_fill.sv
// Main-memory controller: write-through words, block fills with latency.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (wrapped burst order).
module ram_line_fill #(
  parameter int RAM_ADDRESS_BITS = 10,
  parameter int DATA_BITS        = 32,
  parameter int BLOCK_BITS       = 2,
  parameter int LATENCY          = 3
) (
  input logic            clk,
  input logic            reset_n,
  ram_line_fill_if.slave bus
);

  localparam int BLOCK_SIZE = 2 ** BLOCK_BITS;
  localparam int WORDS      = 2 ** RAM_ADDRESS_BITS;
  localparam int TAG_BITS   = RAM_ADDRESS_BITS - BLOCK_BITS;
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam int BW = BLOCK_BITS + 1;

  localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY);
  localparam logic [CW-1:0] LAT_LAST = CW'(1);
  localparam logic [BW-1:0] BEATS    = BW'(BLOCK_SIZE);

  typedef logic [RAM_ADDRESS_BITS-1:0] addr_t;
  typedef logic [DATA_BITS-1:0]        word_t;
  typedef logic [BLOCK_BITS-1:0]       off_t;
  typedef logic [TAG_BITS-1:0]         blk_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WAIT,
    BURST,
    DONE
  } state_t;

  state_t          state_q;
  addr_t           wr_addr_q;
  word_t           wr_data_q;
  logic            rd_pend_q;
  blk_t            blk_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   beat_q;
  word_t           buf_q  [BLOCK_SIZE];
  logic            busy_q;
  logic            valid_q;
  word_t           data_q [BLOCK_SIZE];
`ifdef CRITICAL_WORD_FIRST_EN
  off_t            off_q;
  logic            early_valid_q;
  word_t           early_data_q;
`endif

  // Each word is stored XOR-ed with its own address, so a
  // zero-initialised array reads back as word i = i.
  word_t           mem_q  [WORDS];

  off_t            beat_off;
  addr_t           rd_addr;
  word_t           rd_word;

  // Address and data of the word captured on the current beat.
  always_comb begin
`ifdef CRITICAL_WORD_FIRST_EN
    beat_off = off_q + beat_q[BLOCK_BITS-1:0];
`else
    beat_off = beat_q[BLOCK_BITS-1:0];
`endif
    rd_addr = {blk_q, beat_off};
    rd_word = mem_q[rd_addr] ^ word_t'(rd_addr);
  end

  // Backing RAM write port; not touched by reset.
  always_ff @(posedge clk) begin
    if (state_q == WRITE) begin
      mem_q[wr_addr_q] <= wr_data_q ^ word_t'(wr_addr_q);
    end
  end

  // Request FSM with registered busy/valid/data outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_pend_q <= 1'b0;
      blk_q     <= '0;
      cnt_q     <= '0;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        buf_q[k]  <= '0;
        data_q[k] <= '0;
      end
`ifdef CRITICAL_WORD_FIRST_EN
      off_q         <= '0;
      early_valid_q <= 1'b0;
      early_data_q  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
      early_valid_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (bus.req_read_en) begin
            blk_q  <= bus.req_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
            cnt_q  <= LAT_LOAD;
            beat_q <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            off_q  <= bus.req_address[BLOCK_BITS-1:0];
`endif
          end
          if (bus.req_write_en) begin
            wr_addr_q <= bus.req_address;
            wr_data_q <= bus.req_write_data;
            rd_pend_q <= bus.req_read_en;
            state_q   <= WRITE;
            busy_q    <= 1'b1;
          end else if (bus.req_read_en) begin
            state_q <= (LATENCY == 0) ? BURST : WAIT;
            busy_q  <= 1'b1;
          end
        end
        WRITE: begin
          rd_pend_q <= 1'b0;
          if (rd_pend_q) begin
            state_q <= (LATENCY == 0) ? BURST : WAIT;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - LAT_LAST;
          if (cnt_q == LAT_LAST) begin
            state_q <= BURST;
          end
        end
        BURST: begin
          if (beat_q == BEATS) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            for (int k = 0; k < BLOCK_SIZE; k++) begin
              data_q[k] <= buf_q[k];
            end
          end else begin
            buf_q[beat_off] <= rd_word;
            beat_q          <= beat_q + BW'(1);
`ifdef CRITICAL_WORD_FIRST_EN
            if (beat_q == '0) begin
              early_valid_q <= 1'b1;
              early_data_q  <= rd_word;
            end
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.ram_valid = valid_q;
  assign bus.ram_data  = data_q;
`ifdef CRITICAL_WORD_FIRST_EN
  assign bus.early_valid = early_valid_q;
  assign bus.early_data  = early_data_q;
`endif

endmodule
